// File: rtl/rv32i_pkg.sv
// Shared types and encodings for the RV32I hazard controller.
// Optional statistics counters are enabled with RV32I_HAZ_STATS_EN.
package rv32i_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 32;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [SEL_W-1:0] FWD_RF = 2'b00;
    localparam logic [SEL_W-1:0] FWD_W  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/rv32i_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// StallCount/FlushCount exist only when RV32I_HAZ_STATS_EN is defined.
interface rv32i_hazard_ctrl_if;
    import rv32i_pkg::*;

    logic [REG_W-1:0] Rs1D, Rs2D;
    logic [REG_W-1:0] Rs1E, Rs2E, RdE;
    logic [REG_W-1:0] RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MulDivStartE;

    logic [SEL_W-1:0] ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE;
    logic             BubbleM;
    logic             MdBusy, MdValid;
`ifdef RV32I_HAZ_STATS_EN
    logic [STAT_W-1:0] StallCount, FlushCount;
`endif

    // Pipeline side: drives register ids and control, receives hazard controls
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, BubbleM, MdBusy, MdValid
`ifdef RV32I_HAZ_STATS_EN
        , input StallCount, FlushCount
`endif
    );

    // Controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, BubbleM, MdBusy, MdValid
`ifdef RV32I_HAZ_STATS_EN
        , output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/rv32i_fwd_sel.sv
// Forwarding select for one execute-stage operand; memory stage has priority.
module rv32i_fwd_sel
    import rv32i_pkg::*;
(
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rdM,
    input  logic             regWriteM,
    input  logic [REG_W-1:0] rdW,
    input  logic             regWriteW,
    output logic [SEL_W-1:0] fwdSel
);

    logic hitM;
    logic hitW;

    // x0 is hardwired zero, so it never forwards
    assign hitM = regWriteM && (rdM != '0) && (rdM == rsE);
    assign hitW = regWriteW && (rdW != '0) && (rdW == rsE);

    always_comb begin
        fwdSel = FWD_RF;
        if (hitM) begin
            fwdSel = FWD_M;
        end else if (hitW) begin
            fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Hazard/forwarding controller with a multi-cycle mul/div sequencer.
// Define RV32I_HAZ_STATS_EN to add saturating stall/flush counters.
module rv32i_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
)
(
    input logic              clk,
    input logic              rst,
    rv32i_hazard_ctrl_if.slave hz
);

    mdState_t         state;
    logic [CNT_W-1:0] count;
    logic             lwStall;
    logic             mdStall;
    logic             stallAny;
    logic             flushE;

    rv32i_fwd_sel uFwdA (
        .rsE       (hz.Rs1E),
        .rdM       (hz.RdM),
        .regWriteM (hz.RegWriteM),
        .rdW       (hz.RdW),
        .regWriteW (hz.RegWriteW),
        .fwdSel    (hz.ForwardAE)
    );

    rv32i_fwd_sel uFwdB (
        .rsE       (hz.Rs2E),
        .rdM       (hz.RdM),
        .regWriteM (hz.RegWriteM),
        .rdW       (hz.RdW),
        .regWriteW (hz.RegWriteW),
        .fwdSel    (hz.ForwardBE)
    );

    // Mul/div sequencer: start cycle, MD_CYCLES busy cycles, one done cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.MulDivStartE) begin
                        state <= BUSY;
                        count <= CNT_W'(MD_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign lwStall = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != '0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign mdStall = ((state == IDLE) && hz.MulDivStartE) || (state == BUSY);

    // The mul/div op owns execute, so nothing may flush around it
    assign stallAny = lwStall || mdStall;
    assign flushE   = (lwStall || hz.PCSrcE) && !mdStall;

    assign hz.StallF  = stallAny;
    assign hz.StallD  = stallAny;
    assign hz.StallE  = mdStall;
    assign hz.BubbleM = mdStall;
    assign hz.FlushD  = hz.PCSrcE && !mdStall;
    assign hz.FlushE  = flushE;
    assign hz.MdValid = (state == DONE);
    assign hz.MdBusy  = (state != IDLE);

`ifdef RV32I_HAZ_STATS_EN
    logic [STAT_W-1:0] stallCount;
    logic [STAT_W-1:0] flushCount;

    // Saturating event counters; flushes counted only when branch-caused
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallAny && (stallCount != '1)) begin
                stallCount <= stallCount + STAT_W'(1);
            end
            if (flushE && hz.PCSrcE && (flushCount != '1)) begin
                flushCount <= flushCount + STAT_W'(1);
            end
        end
    end

    assign hz.StallCount = stallCount;
    assign hz.FlushCount = flushCount;
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Randomized plus directed bench for rv32i_hazard_ctrl against a behavioural model.
module tb_rv32i_hazard_ctrl;

    localparam int MDC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_hazard_ctrl_if hz();

    rv32i_hazard_ctrl #(.MD_CYCLES(MDC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int total = 0;
    int bad   = 0;
    // Cycles since a mul/div started: -1 idle, 1..MDC busy, MDC+1 done
    int age = -1;
    longint unsigned mStall = 0;
    longint unsigned mFlush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [4:0] rs, input logic [4:0] rdm,
                                          input logic wm, input logic [4:0] rdw, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkAll(output bit stD, output bit brFlush);
        bit lw, md, fE;
        lw = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        md = (age < 0 && hz.MulDivStartE) || (age >= 1 && age <= MDC);
        fE = (lw || hz.PCSrcE) && !md;
        stD = lw || md;
        brFlush = fE && hz.PCSrcE;
        chk("ForwardAE", 32'(hz.ForwardAE), 32'(fwdRef(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW)));
        chk("ForwardBE", 32'(hz.ForwardBE), 32'(fwdRef(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW)));
        chk("StallF", 32'(hz.StallF), 32'(stD));
        chk("StallD", 32'(hz.StallD), 32'(stD));
        chk("StallE", 32'(hz.StallE), 32'(md));
        chk("BubbleM", 32'(hz.BubbleM), 32'(md));
        chk("FlushD", 32'(hz.FlushD), 32'(hz.PCSrcE && !md));
        chk("FlushE", 32'(hz.FlushE), 32'(fE));
        chk("MdValid", 32'(hz.MdValid), 32'(age == MDC + 1));
        chk("MdBusy", 32'(hz.MdBusy), 32'(age >= 1));
`ifdef RV32I_HAZ_STATS_EN
        chk("StallCount", hz.StallCount, 32'(mStall));
        chk("FlushCount", hz.FlushCount, 32'(mFlush));
`endif
    endtask

    // Check this cycle's outputs, then advance the model across the clock edge
    task automatic step();
        bit stD, brFlush;
        @(negedge clk);
        checkAll(stD, brFlush);
        @(posedge clk);
        if (!rst) begin
            age = -1;
            mStall = 0;
            mFlush = 0;
        end else begin
            if (stD && mStall < 64'hFFFF_FFFF) mStall++;
            if (brFlush && mFlush < 64'hFFFF_FFFF) mFlush++;
            if (age < 0) begin
                if (hz.MulDivStartE) age = 1;
            end else if (age == MDC + 1) begin
                age = -1;
            end else begin
                age++;
            end
        end
        #1;
    endtask

    task automatic idleIn();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
        hz.PCSrcE = 1'b0; hz.MulDivStartE = 1'b0;
    endtask

    initial begin
        idleIn();
        // Reset edge before any check
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_StallF", 32'(hz.StallF), 32'd0);
        chk("rst_FlushE", 32'(hz.FlushE), 32'd0);
        chk("rst_MdBusy", 32'(hz.MdBusy), 32'd0);
        chk("rst_MdValid", 32'(hz.MdValid), 32'd0);
        chk("rst_Fwd", 32'({hz.ForwardAE, hz.ForwardBE}), 32'd0);
        step();

        // Forwarding priority and x0
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd5;
        #1 chk("fwd_M_wins", 32'(hz.ForwardAE), 32'd2);
        step();
        hz.RdM = 5'd0;
        #1 chk("fwd_W", 32'(hz.ForwardAE), 32'd1);
        step();
        hz.RdM = 5'd5; hz.Rs1E = 5'd0;
        #1 chk("fwd_x0", 32'(hz.ForwardAE), 32'd0);
        step();
        idleIn();

        // Load-use
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        chk("lw_StallD", 32'(hz.StallD), 32'd1);
        chk("lw_FlushE", 32'(hz.FlushE), 32'd1);
        chk("lw_FlushD", 32'(hz.FlushD), 32'd0);
        step();
        hz.RdE = 5'd0; hz.Rs2D = 5'd0;
        #1 chk("lw_x0", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'd0);
        step();
        idleIn();

        // Taken branch alone
        hz.PCSrcE = 1'b1;
        #1;
        chk("br_Flush", 32'({hz.FlushD, hz.FlushE}), 32'd3);
        chk("br_Stall", 32'({hz.StallF, hz.StallD, hz.StallE}), 32'd0);
        step();
        idleIn();

        // Mul/div held for its whole residency; branch during busy is ignored
        hz.MulDivStartE = 1'b1;
        for (int i = 0; i <= MDC; i++) begin
            hz.PCSrcE = (i == 2);
            #1;
            chk("md_StallE", 32'(hz.StallE), 32'd1);
            chk("md_Busy", 32'(hz.MdBusy), 32'(i > 0));
            chk("md_NoValid", 32'(hz.MdValid), 32'd0);
            if (i == 2) chk("md_NoFlush", 32'({hz.FlushD, hz.FlushE}), 32'd0);
            step();
        end
        hz.PCSrcE = 1'b0;
        #1;
        chk("md_Valid", 32'(hz.MdValid), 32'd1);
        chk("md_DoneNoStall", 32'(hz.StallE), 32'd0);
        step();
        hz.MulDivStartE = 1'b0;
        #1 chk("md_Idle", 32'({hz.MdBusy, hz.MdValid}), 32'd0);
        step();

        // Reset aborts a busy op
        hz.MulDivStartE = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        hz.MulDivStartE = 1'b0;
        #1;
        chk("abort_Busy", 32'(hz.MdBusy), 32'd0);
        chk("abort_StallE", 32'(hz.StallE), 32'd0);
        for (int i = 0; i < MDC + 3; i++) begin
            chk("abort_NoValid", 32'(hz.MdValid), 32'd0);
            step();
        end

`ifdef RV32I_HAZ_STATS_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1 chk("stat_rst", hz.StallCount | hz.FlushCount, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idleIn();
            hz.ResultSrcE = 2'b01; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            idleIn();
            hz.PCSrcE = 1'b1;
            step();
        end
        idleIn();
        #1;
        chk("stat_Stall3", hz.StallCount, 32'd3);
        chk("stat_Flush2", hz.FlushCount, 32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1 chk("stat_cleared", hz.StallCount | hz.FlushCount, 32'd0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
            hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
            hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
            hz.RdW  = 5'($urandom_range(0, 7));
            hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
            hz.ResultSrcE = 2'($urandom);
            hz.PCSrcE = ($urandom_range(0, 3) == 0);
            hz.MulDivStartE = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 39) != 0);
            step();
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
